fetch_stage: RTL and testbench

- Instruction fetch stage. Owns the PC and issues word fetches to instruction memory over a valid/ready request channel with variable-latency responses.
- Buffers returned instructions in a small FIFO that presents {pc, instr} to decode, where the instruction feeds the immediate generator and control decode.
- Handles branch/jump redirects from execute, including discarding stale in-flight responses.

---
 rtl/fetch_stage.sv | 160 ++++++++++++++++
 tb/tb_fetch_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one outstanding word fetch at a time,
// and buffers returned {pc, instr} pairs for decode. Handles redirects from execute.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
);
    localparam int               PTR_W   = $clog2(BUF_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t           state;
    logic [31:0]      pc;
    logic [31:0]      req_pc;
    logic             inflight;
    logic             drop;
    logic [31:0]      fifo_pc    [BUF_DEPTH];
    logic [31:0]      fifo_instr [BUF_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;

    logic             req_fire;
    logic             resp_take;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count_nxt;
    logic             slot_free;
    logic [31:0]      redirect_aligned;

    assign req_fire         = imem_req_valid && imem_req_ready;
    assign resp_take        = (state == S_WAIT) && inflight && imem_resp_valid;
    assign push             = resp_take && !drop && !redirect_valid;
    assign pop              = id_valid && id_ready;
    assign count_nxt        = count + CNT_W'(push) - CNT_W'(pop);
    // Only evaluated when no request will be in flight next cycle.
    assign slot_free        = count_nxt < DEPTH_C;
    assign redirect_aligned = redirect_pc & ~32'h0000_0003;

    assign imem_addr = pc;
    assign id_valid  = (count != '0);
    assign id_pc     = fifo_pc[rptr];
    assign id_instr  = fifo_instr[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            req_pc         <= RESET_PC;
            inflight       <= 1'b0;
            drop           <= 1'b0;
            imem_req_valid <= 1'b0;
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            pc    <= redirect_aligned;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            case (state)
                S_REQ: begin
                    imem_req_valid <= 1'b0;
                    if (req_fire) begin
                        // The accepted request targets the old path; its response is discarded.
                        inflight <= 1'b1;
                        drop     <= 1'b1;
                        state    <= S_WAIT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (resp_take) begin
                        inflight       <= 1'b0;
                        drop           <= 1'b0;
                        state          <= S_REQ;
                        imem_req_valid <= 1'b1;
                    end else begin
                        drop <= 1'b1;
                    end
                end
                default: begin
                    state          <= S_REQ;
                    imem_req_valid <= 1'b1;
                end
            endcase
        end else begin
            if (push) begin
                fifo_pc[wptr]    <= req_pc;
                fifo_instr[wptr] <= imem_resp_data;
                wptr             <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            count <= count_nxt;

            case (state)
                S_IDLE: begin
                    if (slot_free) begin
                        state          <= S_REQ;
                        imem_req_valid <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (req_fire) begin
                        req_pc         <= pc;
                        pc             <= pc + 32'd4;
                        inflight       <= 1'b1;
                        imem_req_valid <= 1'b0;
                        state          <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (resp_take) begin
                        inflight <= 1'b0;
                        drop     <= 1'b0;
                        if (slot_free) begin
                            state          <= S_REQ;
                            imem_req_valid <= 1'b1;
                        end else begin
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (slot_free) begin
                        state          <= S_REQ;
                        imem_req_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

    // The in-flight reservation guarantees a free slot whenever a response is pushed.
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == DEPTH_C)));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a negedge-driven memory responder with programmable
// latency, a redirect vector table, and hand-written multi-cycle corner sequences.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    localparam logic [31:0] XOR_K = 32'hA5A5_0000;

    fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int pend = 0;
    int stray_req = 0;
    int stray_seen = 0;
    logic [31:0] pend_addr = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: sees the handshake before the edge, answers lat cycles later.
    always @(negedge clk) begin
        imem_resp_valid = 1'b0;
        if (!rst_n) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = pend_addr ^ XOR_K;
                end
            end
            if (stray_seen != stray_req) begin
                stray_seen      = stray_req;
                imem_resp_valid = 1'b1;
                imem_resp_data  = 32'hDEAD_BEEF;
            end
            if (imem_req_valid && imem_req_ready) begin
                pend      = lat;
                pend_addr = imem_addr;
            end
        end
    end

    typedef struct {
        logic [31:0] target;
        int          lat;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout actual=none expected=event", name);
    endtask

    task automatic expect_pop(input string name, input logic [31:0] exp_pc, output int at);
        bit found = 1'b0;
        at = -1;
        for (int i = 0; i < 60 && !found; i++) begin
            if (id_valid && id_ready) begin
                found = 1'b1;
                at    = cyc;
                chk({name, "_pc"}, id_pc, exp_pc);
                chk({name, "_instr"}, id_instr, exp_pc ^ XOR_K);
            end
            step();
        end
        if (!found) timeout(name);
    endtask

    task automatic wait_hs(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (imem_req_valid && imem_req_ready) found = 1'b1;
            else step();
        end
        if (!found) timeout(name);
    endtask

    task automatic wait_req(input string name, output bit saw_valid);
        bit found = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (id_valid) saw_valid = 1'b1;
            if (imem_req_valid) found = 1'b1;
            else step();
        end
        if (!found) timeout(name);
    endtask

    initial begin
        int  t8, tc, tdummy;
        bit  saw;
        logic [31:0] a0;

        vecs[0] = '{target: 32'h0000_0103, lat: 1, exp0: 32'h0000_0100, exp1: 32'h0000_0104};
        vecs[1] = '{target: 32'hFFFF_FFFE, lat: 1, exp0: 32'hFFFF_FFFC, exp1: 32'h0000_0000};
        vecs[2] = '{target: 32'h0000_2001, lat: 2, exp0: 32'h0000_2000, exp1: 32'h0000_2004};
        vecs[3] = '{target: 32'h0000_0040, lat: 3, exp0: 32'h0000_0040, exp1: 32'h0000_0044};

        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        lat            = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        rst_n = 1'b1;
        chk("idle_req_valid", {31'b0, imem_req_valid}, 32'd0);
        step();
        chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_addr, 32'h0);

        // Steady stream, 1-cycle memory
        expect_pop("s0", 32'h0, tdummy);
        expect_pop("s4", 32'h4, tdummy);
        expect_pop("s8", 32'h8, t8);
        expect_pop("sc", 32'hC, tc);
        chk("throughput", 32'(tc - t8), 32'd2);

        // Redirect vector table
        for (int i = 0; i < 4; i++) begin
            lat = vecs[i].lat;
            repeat (3) step();
            redirect_valid = 1'b1;
            redirect_pc    = vecs[i].target;
            step();
            redirect_valid = 1'b0;
            expect_pop($sformatf("rv%0d_a", i), vecs[i].exp0, tdummy);
            expect_pop($sformatf("rv%0d_b", i), vecs[i].exp1, tdummy);
        end

        // Decode backpressure fills the buffer
        lat      = 1;
        id_ready = 1'b0;
        rst_n    = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("hold_id_valid", {31'b0, id_valid}, 32'd1);
        chk("hold_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("hold_head", id_pc, 32'h0);
        id_ready = 1'b1;
        step();
        chk("reissue_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("reissue_addr", imem_addr, 32'h8);
        chk("hold_second", id_pc, 32'h4);
        expect_pop("bp4", 32'h4, tdummy);
        expect_pop("bp8", 32'h8, tdummy);

        // Redirect while a slow response is outstanding
        lat = 3;
        wait_hs("ro_hs");
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        wait_req("ro_req", saw);
        chk("ro_no_stale", {31'b0, saw}, 32'd0);
        chk("ro_addr", imem_addr, 32'h0000_0100);
        expect_pop("ro", 32'h0000_0100, tdummy);

        // Memory not ready; redirect withdraws the pending request for one cycle
        lat            = 1;
        imem_req_ready = 1'b0;
        wait_req("st_req", saw);
        a0 = imem_addr;
        step();
        chk("stall1_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("stall1_addr", imem_addr, a0);
        step();
        chk("stall2_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("stall2_addr", imem_addr, a0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        step();
        redirect_valid = 1'b0;
        chk("wd_low", {31'b0, imem_req_valid}, 32'd0);
        step();
        chk("wd_high", {31'b0, imem_req_valid}, 32'd1);
        chk("wd_addr", imem_addr, 32'h0000_0300);
        step();
        chk("wd_stable", imem_addr, 32'h0000_0300);
        imem_req_ready = 1'b1;
        expect_pop("wd", 32'h0000_0300, tdummy);

        // Response and redirect on the same edge
        lat = 1;
        wait_hs("sim_hs");
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0500;
        step();
        redirect_valid = 1'b0;
        chk("sim_empty", {31'b0, id_valid}, 32'd0);
        chk("sim_req", {31'b0, imem_req_valid}, 32'd1);
        chk("sim_addr", imem_addr, 32'h0000_0500);
        expect_pop("sim", 32'h0000_0500, tdummy);

        // Asynchronous reset while waiting with a buffered entry, then a stray response
        lat      = 3;
        id_ready = 1'b0;
        saw      = 1'b0;
        for (int i = 0; i < 60 && !saw; i++) begin
            if (id_valid) saw = 1'b1;
            else step();
        end
        if (!saw) timeout("lr_fill");
        wait_hs("lr_hs");
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("ar_id_valid", {31'b0, id_valid}, 32'd0);
        chk("ar_addr", imem_addr, 32'h0);
        chk("ar_id_pc", id_pc, 32'h0);
        chk("ar_id_instr", id_instr, 32'h0);
        step();
        step();
        rst_n     = 1'b1;
        stray_req = stray_req + 1;
        step();
        chk("lr_no_valid", {31'b0, id_valid}, 32'd0);
        chk("lr_req", {31'b0, imem_req_valid}, 32'd1);
        chk("lr_addr", imem_addr, 32'h0);
        id_ready = 1'b1;
        expect_pop("lr", 32'h0, tdummy);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
